im_line_buffer: RTL and testbench

Small direct-mapped instruction line buffer between the CPU's instruction-fetch port (ARADDR_IM/RDATA_IM channel) and the backing instruction memory.
- Accepts 32-bit fetch requests from the CPU and returns the addressed word on a 128-bit response bus, as {96'b0, word}.
- On a hit, it serves the word from a locally held 128-bit line.
- On a miss, it fetches the aligned 16-byte line from memory over a valid/ready read channel.
- It also supports invalidation after a code write or reset of the program image.

---
 rtl/im_lb_pkg.sv | 19 +
 rtl/im_line_buffer_if.sv | 45 ++++
 rtl/im_lb_store.sv | 66 ++++++
 rtl/im_line_buffer.sv | 113 +++++++++++
 tb/tb_im_line_buffer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_lb_pkg.sv
// Shared types and helpers for the instruction line buffer.
// State encoding, line geometry and address helpers.
package im_lb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEM_AR,
      MEM_R,
      RESP
   } state_e;

   localparam int OFFSET_W   = 4;
   localparam int WORD_SEL_W = 2;

   function automatic logic [31:0] line_addr(input logic [31:0] addr);
      return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/im_line_buffer_if.sv
// CPU fetch channel and backing-memory read channel.
// The master side drives the request, the slave side answers.
interface im_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);
   logic [ADDR_W-1:0] ARADDR_IM;
   logic              ARVALID_IM;
   logic              ARREADY_IM;
   logic [LINE_W-1:0] RDATA_IM;
   logic              RVALID_IM;
   logic              RREADY_IM;

   modport master (
      output ARADDR_IM, ARVALID_IM, RREADY_IM,
      input  ARREADY_IM, RDATA_IM, RVALID_IM
   );

   modport slave (
      input  ARADDR_IM, ARVALID_IM, RREADY_IM,
      output ARREADY_IM, RDATA_IM, RVALID_IM
   );
endinterface

interface im_mem_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);
   logic [ADDR_W-1:0] mem_araddr;
   logic              mem_arvalid;
   logic              mem_arready;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              mem_rready;

   modport master (
      output mem_araddr, mem_arvalid, mem_rready,
      input  mem_arready, mem_rdata, mem_rvalid
   );

   modport slave (
      input  mem_araddr, mem_arvalid, mem_rready,
      output mem_arready, mem_rdata, mem_rvalid
   );
endinterface

// File: rtl/im_lb_store.sv
// Direct-mapped tag/valid/data array of the line buffer.
// Combinational lookup, single-entry fill, clear-all invalidate.
module im_lb_store
   import im_lb_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_hit,
   output logic [LINE_W-1:0] rd_line,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              inv
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [TAG_W-1:0]     tag_d  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];
   logic [LINE_W-1:0]    data_d [NUM_LINES];

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0] rd_tag, wr_tag;
   logic             unused_bits;

   assign rd_idx = rd_addr[OFFSET_W +: IDX_W];
   assign rd_tag = rd_addr[ADDR_W-1 -: TAG_W];
   assign wr_idx = wr_addr[OFFSET_W +: IDX_W];
   assign wr_tag = wr_addr[ADDR_W-1 -: TAG_W];
   assign unused_bits = ^{rd_addr[OFFSET_W-1:0], wr_addr[OFFSET_W-1:0]};

   assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_line = data_q[rd_idx];

   // Invalidate overrides a coincident fill so the entry stays invalid.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (we) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
         data_d[wr_idx]  = wr_line;
      end
      if (inv) valid_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/im_line_buffer.sv
// Instruction line buffer: serves fetch words from cached 16-byte
// lines, refilling from memory one line at a time on a miss.
module im_line_buffer
   import im_lb_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 128
) (
   input  logic        clk,
   input  logic        rst,
   im_fetch_if.slave   cpu,
   im_mem_if.master    mem,
   input  logic        invalidate,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic [31:0]       hit_q, hit_d;
   logic [31:0]       miss_q, miss_d;

   logic              accept;
   logic              fill;
   logic              lk_hit;
   logic [LINE_W-1:0] lk_line;

   im_lb_store #(
      .NUM_LINES (NUM_LINES),
      .ADDR_W    (ADDR_W),
      .LINE_W    (LINE_W)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (cpu.ARADDR_IM),
      .rd_hit  (lk_hit),
      .rd_line (lk_line),
      .we      (fill),
      .wr_addr (addr_q),
      .wr_line (mem.mem_rdata),
      .inv     (invalidate)
   );

   // In RESP a new request rides on the response handshake.
   assign cpu.ARREADY_IM = (state_q == IDLE)
                         | ((state_q == RESP) & cpu.RREADY_IM);
   assign accept = cpu.ARVALID_IM & cpu.ARREADY_IM;

   assign cpu.RVALID_IM   = (state_q == RESP);
   assign cpu.RDATA_IM    = {{(LINE_W-32){1'b0}}, word_q};
   assign mem.mem_araddr  = line_addr(addr_q);
   assign mem.mem_arvalid = (state_q == MEM_AR);
   assign mem.mem_rready  = (state_q == MEM_R);
   assign hit_count       = hit_q;
   assign miss_count      = miss_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      fill    = 1'b0;
      unique case (1'b1)
         state_q == MEM_AR: begin
            if (mem.mem_arready) state_d = MEM_R;
         end
         state_q == MEM_R: begin
            if (mem.mem_rvalid) begin
               fill    = 1'b1;
               word_d  = mem.mem_rdata[
                  {addr_q[OFFSET_W-1 -: WORD_SEL_W], 5'd0} +: 32];
               state_d = RESP;
            end
         end
         state_q == RESP: begin
            if (cpu.RREADY_IM) state_d = IDLE;
         end
         default: ;
      endcase
      if (accept) begin
         addr_d = cpu.ARADDR_IM;
         if (lk_hit) begin
            word_d  = lk_line[
               {cpu.ARADDR_IM[OFFSET_W-1 -: WORD_SEL_W], 5'd0} +: 32];
            state_d = RESP;
            hit_d   = hit_q + 32'd1;
         end else begin
            state_d = MEM_AR;
            miss_d  = miss_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

endmodule

// File: tb/tb_im_line_buffer.sv
// Bench for im_line_buffer: directed scenarios plus randomized
// fetch streams against a direct-mapped reference cache model.
module tb_im_line_buffer;

   localparam int NL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        invalidate;
   logic [31:0] hit_count, miss_count;

   im_fetch_if #(.ADDR_W(32), .LINE_W(128)) cpu_if ();
   im_mem_if   #(.ADDR_W(32), .LINE_W(128)) mem_if ();

   im_line_buffer #(
      .NUM_LINES (NL),
      .ADDR_W    (32),
      .LINE_W    (128)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu        (cpu_if),
      .mem        (mem_if),
      .invalidate (invalidate),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: memory image and a direct-mapped line directory
   logic [127:0] mem_img [256];
   bit           m_valid [NL];
   logic [27:0]  m_line  [NL];
   int           exp_hit = 0;
   int           exp_miss = 0;
   logic [31:0]  exp_ar [$];

   typedef struct {
      logic [31:0] word;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb [$];

   function automatic void model_clear();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
   endfunction

   // Memory responder, driven on the falling edge
   int          ar_delay = 0;
   int          r_delay = 0;
   int          m_phase, m_wait, mreq = 0;
   logic [31:0] m_addr;
   bit          m_seen;

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         mem_if.mem_arready = 1'b0;
         mem_if.mem_rvalid  = 1'b0;
         mem_if.mem_rdata   = '0;
         m_phase = 0;
         m_wait  = 0;
         m_seen  = 1'b0;
      end else begin
         case (m_phase)
            0: if (mem_if.mem_arvalid) begin
               if (!m_seen) begin
                  m_seen = 1'b1;
                  m_addr = mem_if.mem_araddr;
               end else begin
                  chk("araddr_hold", mem_if.mem_araddr, m_addr);
               end
               if (m_wait < ar_delay) m_wait++;
               else begin
                  mem_if.mem_arready = 1'b1;
                  mreq++;
                  chk("ar_expected", 128'(exp_ar.size() > 0), 1);
                  if (exp_ar.size() > 0)
                     chk("araddr", m_addr, exp_ar.pop_front());
                  m_phase = 1;
                  m_wait  = 0;
               end
            end
            1: begin
               mem_if.mem_arready = 1'b0;
               m_seen = 1'b0;
               if (m_wait < r_delay) m_wait++;
               else begin
                  mem_if.mem_rvalid = 1'b1;
                  mem_if.mem_rdata  = mem_img[m_addr[11:4]];
                  m_phase = 2;
                  m_wait  = 0;
               end
            end
            default: begin
               mem_if.mem_rvalid = 1'b0;
               mem_if.mem_rdata  = '0;
               m_phase = 0;
            end
         endcase
      end
   end

   task automatic lookup(input logic [31:0] a);
      int          idx;
      logic [27:0] ln;
      exp_t        e;
      ln  = a[31:4];
      idx = int'(a / 16) % NL;
      e.word = mem_img[ln[7:0]][32*int'(a[3:2]) +: 32];
      e.acc  = cyc;
      if (m_valid[idx] && m_line[idx] == ln) begin
         exp_hit++;
         e.lat = 1;
      end else begin
         exp_miss++;
         m_valid[idx] = 1'b1;
         m_line[idx]  = ln;
         e.lat = 3 + ar_delay + r_delay;
         exp_ar.push_back({ln, 4'b0});
      end
      sb.push_back(e);
   endtask

   task automatic run(input logic [31:0] addrs[$], input int rr_pct,
                      input int rr_hold, input bit inv_fill);
      int           ai = 0;
      int           guard = 0;
      int           held = 0;
      bit           first = 1'b1;
      int           m0 = mreq;
      int           x0 = exp_miss;
      logic [127:0] prev = '0;
      while ((ai < addrs.size() || sb.size() > 0) && guard < 3000) begin
         @(negedge clk);
         invalidate = 1'b0;
         if (ai < addrs.size()) begin
            cpu_if.ARVALID_IM = 1'b1;
            cpu_if.ARADDR_IM  = addrs[ai];
         end else begin
            cpu_if.ARVALID_IM = 1'b0;
         end
         if (cpu_if.RVALID_IM)
            cpu_if.RREADY_IM = (held >= rr_hold) &&
                               ($urandom_range(1, 100) <= rr_pct);
         else
            cpu_if.RREADY_IM = 1'($urandom_range(0, 1));
         #1;
         if (inv_fill && mem_if.mem_rready && mem_if.mem_rvalid) begin
            invalidate = 1'b1;
            model_clear();
            inv_fill = 1'b0;
         end
         if (cpu_if.RVALID_IM) begin
            if (sb.size() == 0) begin
               chk("resp_expected", 0, 1);
            end else begin
               if (first) chk("latency", cyc - sb[0].acc, sb[0].lat);
               else chk("rdata_hold", cpu_if.RDATA_IM, prev);
               first = 1'b0;
               prev  = cpu_if.RDATA_IM;
               if (cpu_if.RREADY_IM) begin
                  chk("rdata", cpu_if.RDATA_IM, {96'b0, sb[0].word});
                  void'(sb.pop_front());
                  first = 1'b1;
                  held  = 0;
               end else begin
                  held++;
               end
            end
         end
         if (cpu_if.ARVALID_IM && cpu_if.ARREADY_IM) begin
            lookup(addrs[ai]);
            ai++;
         end
         guard++;
      end
      chk("run_done", sb.size() + addrs.size() - ai, 0);
      @(negedge clk);
      cpu_if.ARVALID_IM = 1'b0;
      cpu_if.RREADY_IM  = 1'b0;
      invalidate = 1'b0;
      chk("mem_reqs", mreq - m0, exp_miss - x0);
   endtask

   task automatic pulse_inv();
      @(negedge clk);
      invalidate = 1'b1;
      model_clear();
      @(negedge clk);
      invalidate = 1'b0;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_hits"}, hit_count, exp_hit);
      chk({tag, "_misses"}, miss_count, exp_miss);
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_arready"}, cpu_if.ARREADY_IM, 1);
      chk({tag, "_rvalid"}, cpu_if.RVALID_IM, 0);
      chk({tag, "_rdata"}, cpu_if.RDATA_IM, 0);
      chk({tag, "_araddr"}, mem_if.mem_araddr, 0);
      chk({tag, "_arvalid"}, mem_if.mem_arvalid, 0);
      chk({tag, "_rready"}, mem_if.mem_rready, 0);
      chk({tag, "_hits"}, hit_count, 0);
      chk({tag, "_misses"}, miss_count, 0);
   endtask

   logic [31:0] q [$];

   initial begin
      rst = 1'b1;
      invalidate = 1'b0;
      cpu_if.ARVALID_IM = 1'b0;
      cpu_if.ARADDR_IM  = '0;
      cpu_if.RREADY_IM  = 1'b0;
      for (int i = 0; i < 256; i++)
         mem_img[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_img[0] = {32'h00000013, 32'h00209463,
                    32'h00000113, 32'h00A00093};
      model_clear();

      repeat (2) @(negedge clk);
      #1 chk_idle_outs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Cold miss on line 0
      q.delete(); q.push_back(32'h0);
      run(q, 100, 0, 0);
      chk_cnt("cold");

      // Back-to-back hits on the same line
      q.delete();
      q.push_back(32'h4); q.push_back(32'h8); q.push_back(32'hC);
      run(q, 100, 0, 0);
      chk_cnt("seq");

      // Conflict eviction on index 0
      q.delete(); q.push_back(32'h40); q.push_back(32'h0);
      run(q, 100, 0, 0);
      chk_cnt("evict");

      // Memory and CPU backpressure
      ar_delay = 3;
      q.delete(); q.push_back(32'h104);
      run(q, 100, 2, 0);
      ar_delay = 0;
      chk_cnt("bp");

      // Invalidate between fetches, then during a fill
      pulse_inv();
      q.delete(); q.push_back(32'h0); q.push_back(32'h10);
      run(q, 100, 0, 0);
      q.delete(); q.push_back(32'h28);
      run(q, 100, 0, 1);
      q.delete(); q.push_back(32'h24);
      run(q, 100, 0, 0);
      chk_cnt("inv");

      // Reset while waiting in MEM_R
      r_delay = 3;
      @(negedge clk);
      cpu_if.ARVALID_IM = 1'b1;
      cpu_if.ARADDR_IM  = 32'h208;
      exp_ar.push_back(32'h200);
      @(negedge clk);
      cpu_if.ARVALID_IM = 1'b0;
      for (int g = 0; g < 20 && !mem_if.mem_rready; g++) @(negedge clk);
      chk("reach_memr", mem_if.mem_rready, 1);
      #2 rst = 1'b1;
      #1 chk_idle_outs("rst_mid");
      exp_hit = 0;
      exp_miss = 0;
      model_clear();
      exp_ar.delete();
      @(negedge clk);
      rst = 1'b0;
      r_delay = 0;
      q.delete(); q.push_back(32'h208);
      run(q, 100, 0, 0);
      chk_cnt("post_rst");

      // Randomized streams
      for (int b = 0; b < 8; b++) begin
         ar_delay = $urandom_range(0, 2);
         r_delay  = $urandom_range(0, 2);
         q.delete();
         for (int k = 0; k < 25; k++)
            q.push_back(32'($urandom_range(0, 32'h1FF)));
         run(q, 70, $urandom_range(0, 1), (b % 3) == 0);
         if (b % 2 == 1) pulse_inv();
      end
      chk_cnt("final");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
